// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM encoding, constants and GF(2^8) / S-box helpers.
// The S-boxes are computed (field inverse plus affine map), not tabulated.
package aes_pkg;

    localparam int AES_NR = 10;
    localparam int AES_W  = 128;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_KEYEXP = 2'd1,
        ST_ROUND  = 2'd2,
        ST_DONE   = 2'd3
    } aes_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            acc = acc ^ (b[i] ? p : 8'h00);
            p   = xtime(p);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        logic [15:0] d;
        d = {a, a} << n;
        return d[15:8];
    endfunction

    // a^254 == a^-1 in GF(2^8); zero maps to zero as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step, forward (dir_i=0) or inverse (dir_i=1).
// Both directions share the single SubWord(RotWord()) stage.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [AES_W-1:0] rk_i,
    input  logic [7:0]       rcon_i,
    input  logic             dir_i,
    output logic [AES_W-1:0] rk_o
);

    logic [31:0] w0_s, w1_s, w2_s, w3_s;
    logic [31:0] sw_in_s, sw_out_s;

    // Inverse step recovers the old w3 first, since it feeds the S-boxes
    always_comb begin
        w0_s = rk_i[127:96];
        w1_s = rk_i[95:64];
        w2_s = rk_i[63:32];
        w3_s = rk_i[31:0];
        if (dir_i) begin
            sw_in_s = w3_s ^ w2_s;
        end else begin
            sw_in_s = w3_s;
        end
        sw_out_s = {sbox(sw_in_s[23:16]), sbox(sw_in_s[15:8]),
                    sbox(sw_in_s[7:0]),   sbox(sw_in_s[31:24])} ^ {rcon_i, 24'h000000};
        if (dir_i) begin
            rk_o = {w0_s ^ sw_out_s, w1_s ^ w0_s, w2_s ^ w1_s, w3_s ^ w2_s};
        end else begin
            rk_o[127:96] = w0_s ^ sw_out_s;
            rk_o[95:64]  = w1_s ^ rk_o[127:96];
            rk_o[63:32]  = w2_s ^ rk_o[95:64];
            rk_o[31:0]   = w3_s ^ rk_o[63:32];
        end
    end

endmodule

// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 inverse cipher, one round per clock, on-chip key schedule.
// Optional macro AES_KEY_CACHE_EN: remembers the last key and its rk10 to skip key expansion.
module aes_inv_cipher
    import aes_pkg::*;
#(
    parameter int NR     = AES_NR,
    parameter int DATA_W = AES_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] cipher_text,
    input  logic [DATA_W-1:0] key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] plain_text,
    output logic              busy
);

    localparam logic [3:0] LAST_RND = 4'(NR);

    aes_state_e        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rk_q, rk_d;
    logic [DATA_W-1:0] st_q, st_d;
    logic [DATA_W-1:0] pt_q, pt_d;
    logic              in_ready_q, out_valid_q, busy_q;
    logic [DATA_W-1:0] step_s, isb_s, ark_s, round_s;
`ifdef AES_KEY_CACHE_EN
    logic [DATA_W-1:0] key_q, key_d;
    logic [DATA_W-1:0] ckey_q, ckey_d;
    logic [DATA_W-1:0] crk_q, crk_d;
    logic              cvld_q, cvld_d;
`endif

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        end
        return o;
    endfunction

    // 09/0b/0d/0e products from one shared xtime chain per byte
    function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
        logic [7:0] b [4];
        logic [7:0] m9 [4], mb [4], md [4], me [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            b[i]  = a[31-8*i -: 8];
            x2    = xtime(b[i]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[i] = x8 ^ b[i];
            mb[i] = x8 ^ x2 ^ b[i];
            md[i] = x8 ^ x4 ^ b[i];
            me[i] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
                inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
    endfunction

    aes_key_step u_key_step (
        .rk_i   (rk_q),
        .rcon_i (rcon(cnt_q)),
        .dir_i  (state_q == ST_ROUND),
        .rk_o   (step_s)
    );

    // Inverse round; step_s already holds rk[cnt-1] while in ROUND
    always_comb begin
        isb_s = inv_sub_bytes(inv_shift_rows(st_q));
        ark_s = isb_s ^ step_s;
        if (cnt_q == 4'd1) begin
            round_s = ark_s;
        end else begin
            round_s = inv_mix_columns(ark_s);
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rk_d    = rk_q;
        st_d    = st_q;
        pt_d    = pt_q;
`ifdef AES_KEY_CACHE_EN
        key_d   = key_q;
        ckey_d  = ckey_q;
        crk_d   = crk_q;
        cvld_d  = cvld_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
`ifdef AES_KEY_CACHE_EN
                    if (cvld_q && (key == ckey_q)) begin
                        rk_d    = crk_q;
                        st_d    = cipher_text ^ crk_q;
                        cnt_d   = LAST_RND;
                        state_d = ST_ROUND;
                    end else begin
                        key_d   = key;
                        rk_d    = key;
                        st_d    = cipher_text;
                        cnt_d   = 4'd1;
                        state_d = ST_KEYEXP;
                    end
`else
                    rk_d    = key;
                    st_d    = cipher_text;
                    cnt_d   = 4'd1;
                    state_d = ST_KEYEXP;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_KEYEXP: begin
                rk_d = step_s;
                if (cnt_q == LAST_RND) begin
                    st_d    = st_q ^ step_s;
                    cnt_d   = LAST_RND;
                    state_d = ST_ROUND;
`ifdef AES_KEY_CACHE_EN
                    ckey_d  = key_q;
                    crk_d   = step_s;
                    cvld_d  = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_ROUND: begin
                rk_d  = step_s;
                st_d  = round_s;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    pt_d    = round_s;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ROUND;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, datapath and registered status flags
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            rk_q        <= '0;
            st_q        <= '0;
            pt_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef AES_KEY_CACHE_EN
            key_q       <= '0;
            ckey_q      <= '0;
            crk_q       <= '0;
            cvld_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rk_q        <= rk_d;
            st_q        <= st_d;
            pt_q        <= pt_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d == ST_KEYEXP) || (state_d == ST_ROUND);
`ifdef AES_KEY_CACHE_EN
            key_q       <= key_d;
            ckey_q      <= ckey_d;
            crk_q       <= crk_d;
            cvld_q      <= cvld_d;
`endif
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign plain_text = pt_q;

endmodule
